uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port serial_in, input, 1, asynchronous UART line, idle high.
REQ-006 SHALL have port data_out, output, 8, received byte.
REQ-007 SHALL have port data_out_valid, output, 1, data_out holds an unconsumed byte.
REQ-008 SHALL have port data_out_ready, input, 1, consumer accepts byte when valid & ready.
REQ-009 SHALL have port framing_error, output, 1, one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a byte is dropped.

Function
REQ-011 SHALL use BIT_TIME = CLOCK_FREQ/BAUD_RATE (integer division) and HALF_TIME = BIT_TIME/2 cycles; counter width = clog2(BIT_TIME)+1.
REQ-012 SHALL pass serial_in through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized value rx.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH; 8N1 framing, LSB first.
REQ-014 IDLE -> START when rx = 0; counter cleared.
REQ-015 START: at HALF_TIME cycles, rx = 0 -> DATA (counter cleared); rx = 1 -> IDLE (glitch rejected, no output, no error).
REQ-016 DATA: sample rx every BIT_TIME cycles into shift register bit i (i = 0..7); after bit 7 -> STOP.
REQ-017 STOP: sample rx BIT_TIME cycles after bit 7; rx = 1 -> byte complete, -> IDLE; rx = 0 -> framing_error pulse, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH -> IDLE only when rx = 1; no start detected while line held low (break).
REQ-019 Completed byte SHALL appear on data_out with data_out_valid = 1 in the cycle after the stop-bit sample.
REQ-020 data_out_valid SHALL clear in the cycle after a valid & ready handshake; data_out stable while valid = 1.
REQ-021 Byte completes while valid = 1 and ready = 0: new byte dropped, data_out unchanged, overrun pulses one cycle.
REQ-022 Byte completes in the same cycle as a valid & ready handshake: new byte loaded, valid stays 1, no overrun.
REQ-023 Reception SHALL proceed independently of data_out_ready (no backpressure on the line).
REQ-024 framing_error and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 rst = 0 SHALL immediately force: state IDLE, counters 0, shift register 0, data_out = 8'h00, data_out_valid = 0, framing_error = 0, overrun = 0, synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output; after release a frame is received only from a new falling edge.

Verification (CLOCK_FREQ = 1600, BAUD_RATE = 100, BIT_TIME = 16)
REQ-027 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), ready = 1 -> data_out = 8'hA5, valid high exactly one cycle, no error pulses.
REQ-028 Low glitch of 4 cycles on idle line -> no valid, no framing_error; following frame 0x3C received correctly.
REQ-029 Frame 0x55 with stop bit 0, line then held low 40 cycles, then high, then frame 0x81 -> one framing_error pulse, no valid for 0x55, 0x81 received.
REQ-030 Frames 0x11 then 0x22 back-to-back, ready = 0 -> data_out = 8'h11 held, one overrun pulse at 0x22 completion; then ready = 1 -> valid clears next cycle.
REQ-031 Holding 0x11, ready raised in exact stop-sample+1 cycle of 0x22 -> data_out = 8'h22, valid stays 1, no overrun.
REQ-032 rst = 0 during bit 3 of a frame -> outputs reset immediately; after release, frame 0xF0 received as 8'hF0.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronized line, mid-bit sampling FSM and a
// single-entry valid/ready output register with framing-error and overrun pulses.
module uart_receiver #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int BIT_TIME  = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_TIME = BIT_TIME / 2;
   localparam int CNT_W     = $clog2(BIT_TIME) + 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TIME - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t           state, state_nxt;
   logic             sync_p0, sync_p1, rx;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             byte_done, stop_bad;

   // stage p0/p1: line synchronizer, idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= serial_in;
         sync_p1 <= sync_p0;
      end
   end

   assign rx = sync_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + 1'b1;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      byte_done   = 1'b0;
      stop_bad    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx) state_nxt = START;
         end
         START: begin
            // re-check the line half a bit in; a short low pulse is dropped silently
            if (cnt == HALF_LAST) begin
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
               state_nxt   = rx ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rx;
               bit_idx_nxt        = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (rx) begin
                  byte_done = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // a held-low line (break) must return high before a new start is accepted
            cnt_nxt = '0;
            if (rx) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // stage p2: output holding register; a completing byte may replace one being consumed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out       <= 8'h00;
         data_out_valid <= 1'b0;
         framing_error  <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         framing_error <= stop_bad;
         overrun       <= 1'b0;
         if (byte_done) begin
            if (!data_out_valid || data_out_ready) begin
               data_out       <= shift;
               data_out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_out_valid && data_out_ready) begin
            data_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: framing, glitch, break,
// overrun, same-cycle handoff and mid-frame reset.
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       serial_in = 1'b1;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready = 1'b0;
   logic       framing_error;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   int         vld_rises = 0, vld_cyc = 0, fe_cnt = 0, ov_cnt = 0, long_pulses = 0;
   logic [7:0] last_byte = 8'h00;
   logic       vld_q = 1'b0, fe_q = 1'b0, ov_q = 1'b0;

   uart_receiver #(.CLOCK_FREQ(1600), .BAUD_RATE(100)) dut (
      .clk            (clk),
      .rst            (rst),
      .serial_in      (serial_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .framing_error  (framing_error),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_out_valid && !vld_q) begin
         vld_rises = vld_rises + 1;
         last_byte = data_out;
      end
      if (data_out_valid) vld_cyc = vld_cyc + 1;
      if (framing_error) fe_cnt = fe_cnt + 1;
      if (overrun) ov_cnt = ov_cnt + 1;
      if ((framing_error && fe_q) || (overrun && ov_q)) long_pulses = long_pulses + 1;
      vld_q = data_out_valid;
      fe_q  = framing_error;
      ov_q  = overrun;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives ncyc cycles of a frame; ready pulses high for one cycle at rdy_pulse (-1 = untouched)
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_pulse,
                             input int ncyc);
      int idx;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         idx = c / 16;
         if (idx == 0) serial_in = 1'b0;
         else if (idx <= 8) serial_in = b[idx-1];
         else serial_in = stop;
         if (c == rdy_pulse) data_out_ready = 1'b1;
         else if (rdy_pulse >= 0 && c == rdy_pulse + 1) data_out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      idle(3);
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
      total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
      total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b want 0", framing_error); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b want 0", overrun); end
      rst = 1'b1;
      idle(10);
   endtask

   task automatic test_basic;
      int r0, c0, f0, o0;
      data_out_ready = 1'b1;
      r0 = vld_rises; c0 = vld_cyc; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(8'hA5, 1'b1, -1, 160);
      idle(5);
      total++; if (vld_rises - r0 !== 1) begin bad++; $display("FAIL a5_count: got %0d want 1", vld_rises - r0); end
      total++; if (last_byte !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", last_byte); end
      total++; if (vld_cyc - c0 !== 1) begin bad++; $display("FAIL a5_valid_len: got %0d want 1", vld_cyc - c0); end
      total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL a5_fe: got %0d want 0", fe_cnt - f0); end
      total++; if (ov_cnt - o0 !== 0) begin bad++; $display("FAIL a5_ov: got %0d want 0", ov_cnt - o0); end
   endtask

   task automatic test_glitch;
      int r0, f0;
      data_out_ready = 1'b1;
      r0 = vld_rises; f0 = fe_cnt;
      serial_in = 1'b0;
      idle(4);
      serial_in = 1'b1;
      idle(30);
      total++; if (vld_rises - r0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", vld_rises - r0); end
      total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt - f0); end
      send_frame(8'h3C, 1'b1, -1, 160);
      idle(5);
      total++; if (vld_rises - r0 !== 1) begin bad++; $display("FAIL glitch_3c_count: got %0d want 1", vld_rises - r0); end
      total++; if (last_byte !== 8'h3C) begin bad++; $display("FAIL glitch_3c_data: got %h want 3c", last_byte); end
   endtask

   task automatic test_break;
      int r0, f0;
      data_out_ready = 1'b1;
      r0 = vld_rises; f0 = fe_cnt;
      send_frame(8'h55, 1'b0, -1, 160);
      idle(40);
      serial_in = 1'b1;
      idle(20);
      total++; if (vld_rises - r0 !== 0) begin bad++; $display("FAIL break_55_valid: got %0d want 0", vld_rises - r0); end
      send_frame(8'h81, 1'b1, -1, 160);
      idle(5);
      total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL break_fe: got %0d want 1", fe_cnt - f0); end
      total++; if (vld_rises - r0 !== 1) begin bad++; $display("FAIL break_81_count: got %0d want 1", vld_rises - r0); end
      total++; if (last_byte !== 8'h81) begin bad++; $display("FAIL break_81_data: got %h want 81", last_byte); end
   endtask

   task automatic test_overrun;
      int r0, o0;
      data_out_ready = 1'b0;
      r0 = vld_rises; o0 = ov_cnt;
      send_frame(8'h11, 1'b1, -1, 160);
      send_frame(8'h22, 1'b1, -1, 160);
      idle(5);
      total++; if (data_out !== 8'h11) begin bad++; $display("FAIL ovr_data: got %h want 11", data_out); end
      total++; if (data_out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", data_out_valid); end
      total++; if (ov_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - o0); end
      total++; if (vld_rises - r0 !== 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", vld_rises - r0); end
      data_out_ready = 1'b1;
      idle(1);
      total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", data_out_valid); end
      idle(3);
   endtask

   task automatic test_back_to_back;
      int o0;
      data_out_ready = 1'b0;
      o0 = ov_cnt;
      send_frame(8'h11, 1'b1, -1, 160);
      send_frame(8'h22, 1'b1, 154, 160);
      idle(5);
      total++; if (data_out !== 8'h22) begin bad++; $display("FAIL b2b_data: got %h want 22", data_out); end
      total++; if (data_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", data_out_valid); end
      total++; if (ov_cnt - o0 !== 0) begin bad++; $display("FAIL b2b_ov: got %0d want 0", ov_cnt - o0); end
      data_out_ready = 1'b1;
      idle(3);
   endtask

   task automatic test_reset_midframe;
      int r0, f0;
      data_out_ready = 1'b0;
      send_frame(8'h3C, 1'b1, -1, 160);
      idle(3);
      send_frame(8'hF0, 1'b1, -1, 72);
      rst = 1'b0;
      #1;
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", data_out); end
      total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", data_out_valid); end
      serial_in = 1'b1;
      idle(3);
      rst = 1'b1;
      idle(20);
      data_out_ready = 1'b1;
      r0 = vld_rises; f0 = fe_cnt;
      total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_output: got %b want 0", data_out_valid); end
      send_frame(8'hF0, 1'b1, -1, 160);
      idle(5);
      total++; if (vld_rises - r0 !== 1) begin bad++; $display("FAIL midrst_f0_count: got %0d want 1", vld_rises - r0); end
      total++; if (last_byte !== 8'hF0) begin bad++; $display("FAIL midrst_f0_data: got %h want f0", last_byte); end
      total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL midrst_fe: got %0d want 0", fe_cnt - f0); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_glitch;
      test_break;
      test_overrun;
      test_back_to_back;
      test_reset_midframe;
      total++; if (long_pulses !== 0) begin bad++; $display("FAIL pulse_width: got %0d want 0", long_pulses); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
